// File: rtl/bus_arbiter2.sv
// Two-master, one-slave round-robin arbiter for the valid/ready bus.
// Ports: clk, resetn; m1*/m2* master ports; s* slave port; timeout pulse.
//   mXvalid/mXaddr/mXwdata/mXwstrb in, mXready/mXrdata out (X = 1, 2)
//   svalid/saddr/swdata/swstrb out, sready/srdata in
//   timeout out: registered one-cycle pulse after a forced completion
module bus_arbiter2 #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024,
    parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        m1valid,
    output logic        m1ready,
    input  logic [31:0] m1addr,
    output logic [31:0] m1rdata,
    input  logic [31:0] m1wdata,
    input  logic [3:0]  m1wstrb,
    input  logic        m2valid,
    output logic        m2ready,
    input  logic [31:0] m2addr,
    output logic [31:0] m2rdata,
    input  logic [31:0] m2wdata,
    input  logic [3:0]  m2wstrb,
    output logic        svalid,
    input  logic        sready,
    output logic [31:0] saddr,
    input  logic [31:0] srdata,
    output logic [31:0] swdata,
    output logic [3:0]  swstrb,
    output logic        timeout
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

    typedef enum logic {
        M1,
        M2
    } mst_e;

    state_e      state_q, state_d;
    mst_e        grant_q, grant_d;
    mst_e        last_q, last_d;
    logic [15:0] cnt_q, cnt_d;
    logic        timeout_q, timeout_d;

    logic        g_valid;
    logic [31:0] g_addr;
    logic [31:0] g_wdata;
    logic [3:0]  g_wstrb;
    logic        g_ready;
    logic [31:0] g_rdata;
    logic        to_hit;

    // Granted master's request, muxed once for the forwarding path.
    always_comb begin
        g_valid = m1valid;
        g_addr  = m1addr;
        g_wdata = m1wdata;
        g_wstrb = m1wstrb;
        if (grant_q == M2) begin
            g_valid = m2valid;
            g_addr  = m2addr;
            g_wdata = m2wdata;
            g_wstrb = m2wstrb;
        end
    end

    // sready beats the timeout when both land in the same cycle.
    assign to_hit = (TIMEOUT_CYCLES != 16'd0)
                 && (cnt_q == TIMEOUT_CYCLES)
                 && !sready;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        svalid    = 1'b0;
        saddr     = 32'd0;
        swdata    = 32'd0;
        swstrb    = 4'd0;
        g_ready   = 1'b0;
        g_rdata   = 32'd0;
        unique case (state_q)
            IDLE: begin
                cnt_d = 16'd0;
                if (m1valid && m2valid) begin
                    grant_d = (last_q == M1) ? M2 : M1;
                    state_d = BUSY;
                end else if (m1valid) begin
                    grant_d = M1;
                    state_d = BUSY;
                end else if (m2valid) begin
                    grant_d = M2;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                svalid = g_valid && !to_hit;
                saddr  = g_addr;
                swdata = g_wdata;
                swstrb = g_wstrb;
                if (!g_valid) begin
                    // Master abandoned its request: close quietly.
                    state_d = IDLE;
                    last_d  = grant_q;
                    cnt_d   = 16'd0;
                end else if (sready) begin
                    g_ready = 1'b1;
                    g_rdata = srdata;
                    state_d = IDLE;
                    last_d  = grant_q;
                    cnt_d   = 16'd0;
                end else if (to_hit) begin
                    g_ready   = 1'b1;
                    g_rdata   = ERR_RDATA;
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                    last_d    = grant_q;
                    cnt_d     = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
        endcase
    end

    assign m1ready = g_ready && (grant_q == M1);
    assign m2ready = g_ready && (grant_q == M2);
    assign m1rdata = (grant_q == M1) ? g_rdata : 32'd0;
    assign m2rdata = (grant_q == M2) ? g_rdata : 32'd0;
    assign timeout = timeout_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= IDLE;
            grant_q   <= M1;
            last_q    <= M2;
            cnt_q     <= 16'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

endmodule

// File: tb/tb_bus_arbiter2.sv
// Self-checking bench for bus_arbiter2 (directed + random transactions).
// Expected behaviour comes from a transaction-level round-robin model.
module tb_bus_arbiter2;

    localparam int T = 4;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        resetn;
    logic        m1valid, m2valid;
    logic        m1ready, m2ready;
    logic [31:0] m1addr, m2addr;
    logic [31:0] m1rdata, m2rdata;
    logic [31:0] m1wdata, m2wdata;
    logic [3:0]  m1wstrb, m2wstrb;
    logic        svalid, sready;
    logic [31:0] saddr, srdata, swdata;
    logic [3:0]  swstrb;
    logic        timeout;

    int nvec = 0;
    int nfail = 0;
    int last_srv = 2;
    bit exp_to = 1'b0;

    bus_arbiter2 #(
        .TIMEOUT_CYCLES(16'd4),
        .ERR_RDATA(ERR)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .m1valid(m1valid),
        .m1ready(m1ready),
        .m1addr(m1addr),
        .m1rdata(m1rdata),
        .m1wdata(m1wdata),
        .m1wstrb(m1wstrb),
        .m2valid(m2valid),
        .m2ready(m2ready),
        .m2addr(m2addr),
        .m2rdata(m2rdata),
        .m2wdata(m2wdata),
        .m2wstrb(m2wstrb),
        .svalid(svalid),
        .sready(sready),
        .saddr(saddr),
        .srdata(srdata),
        .swdata(swdata),
        .swstrb(swstrb),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_svalid"}, {31'd0, svalid}, 32'd0);
        chk({tag, "_rdy"}, {30'd0, m1ready, m2ready}, 32'd0);
        chk({tag, "_saddr"}, saddr, 32'd0);
        chk({tag, "_rd"}, m1rdata | m2rdata, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn  = 1'b0;
        m1valid = 1'b0;
        m2valid = 1'b0;
        sready  = 1'b0;
        @(negedge clk);
        #1;
        chk_quiet("rst");
        chk("rst_timeout", {31'd0, timeout}, 32'd0);
        resetn   = 1'b1;
        last_srv = 2;
        exp_to   = 1'b0;
    endtask

    task automatic idle_cycle(input bit sr);
        @(negedge clk);
        m1valid = 1'b0;
        m2valid = 1'b0;
        sready  = sr;
        #1;
        chk_quiet("idle");
        chk("idle_timeout", {31'd0, timeout}, {31'd0, exp_to});
        exp_to = 1'b0;
    endtask

    // One arbitrated transaction; lat = slave wait states before sready.
    task automatic txn(input bit r1, input bit r2, input int lat,
                       input logic [31:0] a1, input logic [31:0] a2,
                       input logic [31:0] w1, input logic [31:0] w2,
                       input logic [3:0] s1, input logic [3:0] s2,
                       input logic [31:0] rd);
        int w;
        int nb;
        bit tmo;
        logic [31:0] ea, ew;
        logic [3:0]  es;
        logic [1:0]  erdy;
        if (r1 && r2) w = (last_srv == 1) ? 2 : 1;
        else w = r1 ? 1 : 2;
        tmo = (lat > T);
        nb  = tmo ? T + 1 : lat + 1;
        ea  = (w == 1) ? a1 : a2;
        ew  = (w == 1) ? w1 : w2;
        es  = (w == 1) ? s1 : s2;
        erdy = (w == 1) ? 2'b10 : 2'b01;
        @(negedge clk);
        m1valid = r1;
        m2valid = r2;
        m1addr  = a1;
        m2addr  = a2;
        m1wdata = w1;
        m2wdata = w2;
        m1wstrb = s1;
        m2wstrb = s2;
        srdata  = rd;
        sready  = 1'b0;
        #1;
        chk_quiet("arb");
        chk("arb_timeout", {31'd0, timeout}, {31'd0, exp_to});
        for (int k = 1; k <= nb; k++) begin
            @(negedge clk);
            sready = (!tmo && k == nb);
            #1;
            chk("svalid", {31'd0, svalid},
                {31'd0, (k < nb) || !tmo});
            chk("saddr", saddr, ea);
            chk("swdata", swdata, ew);
            chk("swstrb", {28'd0, swstrb}, {28'd0, es});
            chk("ready", {30'd0, m1ready, m2ready},
                (k == nb) ? {30'd0, erdy} : 32'd0);
            chk("rdata_g", (w == 1) ? m1rdata : m2rdata,
                (k == nb) ? (tmo ? ERR : rd) : 32'd0);
            chk("rdata_o", (w == 1) ? m2rdata : m1rdata, 32'd0);
            chk("timeout_busy", {31'd0, timeout}, 32'd0);
        end
        last_srv = w;
        exp_to   = tmo;
    endtask

    initial begin
        bit p1, p2, r1, r2;
        resetn  = 1'b0;
        m1valid = 1'b0;
        m2valid = 1'b0;
        m1addr  = '0;
        m2addr  = '0;
        m1wdata = '0;
        m2wdata = '0;
        m1wstrb = '0;
        m2wstrb = '0;
        sready  = 1'b0;
        srdata  = '0;

        do_reset();

        // Single M1 read, zero-wait slave, then an IDLE cycle.
        txn(1, 0, 0, 32'h100, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0,
            32'h1234_5678);
        idle_cycle(1'b0);

        // Both held: M1, M2, M1, M2.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            txn(1, 1, 0, 32'hA000_0000 + i, 32'hB000_0000 + i,
                32'h1111_0000 + i, 32'h2222_0000 + i, 4'h3, 4'hC,
                32'h5555_0000 + i);
        end
        idle_cycle(1'b1);

        // M2 write with three wait states.
        txn(0, 1, 3, 32'h0, 32'h200, 32'h0, 32'hCAFE_F00D, 4'h0,
            4'hF, 32'h0);
        idle_cycle(1'b0);

        // Timeout, then sready coinciding with the timeout cycle.
        txn(1, 0, 9, 32'h300, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0,
            32'h7777_7777);
        txn(1, 0, T, 32'h304, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0,
            32'h8888_8888);
        idle_cycle(1'b0);

        // Reset in the 2nd BUSY cycle.
        do_reset();
        @(negedge clk);
        m1valid = 1'b1;
        m1addr  = 32'h400;
        #1;
        chk("rm_idle_svalid", {31'd0, svalid}, 32'd0);
        @(negedge clk);
        #1;
        chk("rm_busy_svalid", {31'd0, svalid}, 32'd1);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("rm_busy2_rdy", {31'd0, m1ready}, 32'd0);
        @(negedge clk);
        m1valid = 1'b0;
        #1;
        chk_quiet("rm_after");
        chk("rm_timeout", {31'd0, timeout}, 32'd0);
        resetn   = 1'b1;
        last_srv = 2;
        exp_to   = 1'b0;
        txn(1, 1, 1, 32'h410, 32'h420, 32'h0, 32'h0, 4'h0, 4'h0,
            32'h4242_4242);
        idle_cycle(1'b0);

        // Granted master drops valid while BUSY.
        do_reset();
        @(negedge clk);
        m1valid = 1'b1;
        m2valid = 1'b1;
        m1addr  = 32'h500;
        m2addr  = 32'h600;
        #1;
        chk("dv_idle_svalid", {31'd0, svalid}, 32'd0);
        @(negedge clk);
        m1valid = 1'b0;
        #1;
        chk("dv_svalid", {31'd0, svalid}, 32'd0);
        chk("dv_rdy", {30'd0, m1ready, m2ready}, 32'd0);
        last_srv = 1;
        txn(0, 1, 0, 32'h0, 32'h600, 32'h0, 32'h0, 4'h0, 4'h0,
            32'h6666_6666);
        idle_cycle(1'b0);

        // Random traffic; a losing requester keeps requesting.
        do_reset();
        p1 = 1'b0;
        p2 = 1'b0;
        for (int i = 0; i < 60; i++) begin
            r1 = p1 | $urandom_range(0, 1);
            r2 = p2 | $urandom_range(0, 1);
            if (!r1 && !r2) begin
                idle_cycle($urandom_range(0, 1));
            end else begin
                txn(r1, r2, $urandom_range(0, 6),
                    $urandom, $urandom, $urandom, $urandom,
                    4'($urandom), 4'($urandom), $urandom);
                p1 = r1 && (last_srv != 1);
                p2 = r2 && (last_srv != 2);
            end
        end
        idle_cycle(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 nvec, nfail);
        $finish;
    end

endmodule
